// File: rtl/perlin_anim_ctrl.sv
// Animation time scheduler for the Perlin noise display: advances t at VGA frame
// starts, with run/pause/single-step/load/ping-pong and frame-aligned config commits.
module perlin_anim_ctrl #(
  parameter int TW = 20,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [YW-1:0] y_px,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [1:0]    cfg_addr,
  input  logic [TW-1:0] cfg_data,
  output logic [TW-1:0] t,
  output logic          frame_tick,
  output logic          dir,
  output logic          running
);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_SPEED  = 2'd1;
  localparam logic [1:0] A_TLOAD  = 2'd2;
  localparam logic [1:0] A_TLIMIT = 2'd3;

  logic [YW-1:0] prev_y_q,   prev_y_d;
  logic          pend_vld_q, pend_vld_d;
  logic [1:0]    pend_addr_q, pend_addr_d;
  logic [TW-1:0] pend_data_q, pend_data_d;
  logic          run_q,      run_d;
  logic          pp_q,       pp_d;
  logic [3:0]    step_q,     step_d;
  logic [3:0]    div_q,      div_d;
  logic [TW-1:0] limit_q,    limit_d;
  logic          step_req_q, step_req_d;
  logic [TW-1:0] t_q,        t_d;
  logic          dir_q,      dir_d;
  logic          tick_q,     tick_d;
  logic [3:0]    div_cnt_q,  div_cnt_d;

  logic          fs;
  logic          commit;
  logic          load;
  logic          sreq_e;
  logic          run_e, pp_e;
  logic [3:0]    step_e, div_e;
  logic [TW-1:0] limit_e;
  logic [TW:0]   sum_w;
  logic [TW-1:0] adv_t;
  logic          adv_dir;

  assign fs         = (prev_y_q != y_px) && (y_px == '0);
  assign commit     = fs && pend_vld_q;
  assign load       = commit && (pend_addr_q == A_TLOAD);
  assign cfg_ready  = !pend_vld_q;
  assign t          = t_q;
  assign dir        = dir_q;
  assign frame_tick = tick_q;
  assign running    = run_q;

  // Register values as they stand after this edge's commit, so a committed
  // write already governs the advance decided on the same frame start.
  always_comb begin
    run_e   = run_q;
    pp_e    = pp_q;
    step_e  = step_q;
    div_e   = div_q;
    limit_e = limit_q;
    sreq_e  = step_req_q;
    if (commit) begin
      case (pend_addr_q)
        A_CTRL: begin
          run_e  = pend_data_q[0];
          pp_e   = pend_data_q[1];
          sreq_e = step_req_q | pend_data_q[2];
        end
        A_SPEED: begin
          step_e = pend_data_q[3:0];
          div_e  = pend_data_q[7:4];
        end
        A_TLIMIT: limit_e = pend_data_q;
        default: ;
      endcase
    end
  end

  // Sum carries an extra bit so the ping-pong upper-bound compare never wraps.
  always_comb begin
    sum_w   = {1'b0, t_q} + {{(TW - 3){1'b0}}, step_e};
    adv_t   = sum_w[TW-1:0];
    adv_dir = dir_q;
    if (pp_e) begin
      if (!dir_q) begin
        if (sum_w >= {1'b0, limit_e}) begin
          adv_t   = limit_e;
          adv_dir = 1'b1;
        end
      end else begin
        if (t_q <= {{(TW - 4){1'b0}}, step_e}) begin
          adv_t   = '0;
          adv_dir = 1'b0;
        end else begin
          adv_t = t_q - {{(TW - 4){1'b0}}, step_e};
        end
      end
    end
  end

  always_comb begin
    prev_y_d    = y_px;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    run_d       = run_q;
    pp_d        = pp_q;
    step_d      = step_q;
    div_d       = div_q;
    limit_d     = limit_q;
    step_req_d  = step_req_q;
    t_d         = t_q;
    dir_d       = dir_q;
    tick_d      = 1'b0;
    div_cnt_d   = div_cnt_q;

    // Accept and commit are exclusive: accept needs an empty slot, commit a full one.
    if (cfg_valid && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = cfg_addr;
      pend_data_d = cfg_data;
    end else if (fs) begin
      pend_vld_d = 1'b0;
    end

    if (fs) begin
      run_d      = run_e;
      pp_d       = pp_e;
      step_d     = step_e;
      div_d      = div_e;
      limit_d    = limit_e;
      step_req_d = sreq_e;
      if (load) begin
        t_d       = pend_data_q;
        dir_d     = 1'b0;
        div_cnt_d = '0;
        tick_d    = 1'b1;
      end else if (sreq_e) begin
        t_d        = adv_t;
        dir_d      = adv_dir;
        div_cnt_d  = '0;
        step_req_d = 1'b0;
        tick_d     = 1'b1;
      end else if (run_e) begin
        if (div_cnt_q == div_e) begin
          t_d       = adv_t;
          dir_d     = adv_dir;
          div_cnt_d = '0;
          tick_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_y_q    <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      run_q       <= 1'b1;
      pp_q        <= 1'b0;
      step_q      <= 4'd1;
      div_q       <= 4'd0;
      limit_q     <= '1;
      step_req_q  <= 1'b0;
      t_q         <= '0;
      dir_q       <= 1'b0;
      tick_q      <= 1'b0;
      div_cnt_q   <= '0;
    end else begin
      prev_y_q    <= prev_y_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      run_q       <= run_d;
      pp_q        <= pp_d;
      step_q      <= step_d;
      div_q       <= div_d;
      limit_q     <= limit_d;
      step_req_q  <= step_req_d;
      t_q         <= t_d;
      dir_q       <= dir_d;
      tick_q      <= tick_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_perlin_anim_ctrl.sv
// Directed bench for perlin_anim_ctrl: full 525-line frames with config writes
// placed mid-frame, expected t/dir/tick sequences worked out by hand.
module tb_perlin_anim_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  y_px;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_addr;
  logic [19:0] cfg_data;
  logic [19:0] t;
  logic        frame_tick;
  logic        dir;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks;

  perlin_anim_ctrl #(.TW(20), .YW(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_px      (y_px),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .t         (t),
    .frame_tick(frame_tick),
    .dir       (dir),
    .running   (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) ticks <= 0;
    else if (frame_tick) ticks <= ticks + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full frame: y = 1..524 then 0. The return to 0 is the frame-start edge;
  // an optional write is presented at line 100.
  task automatic run_frame(input bit wr, input logic [1:0] a, input logic [19:0] d);
    for (int y = 1; y < 525; y++) begin
      y_px = 10'(y);
      if (wr && y == 100) begin
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
      end
      cyc();
      if (wr && y == 100) begin
        cfg_valid = 1'b0;
        check("ready_low_after_write", 32'(cfg_ready), 32'd0);
      end
    end
    y_px = '0;
    cyc();
    if (wr) check("ready_high_after_fs", 32'(cfg_ready), 32'd1);
  endtask

  task automatic frame_expect(input string tag, input bit wr, input logic [1:0] a,
                              input logic [19:0] d, input logic [19:0] exp_t,
                              input logic exp_tick, input logic exp_dir);
    run_frame(wr, a, d);
    check({tag, "_t"}, 32'(t), 32'(exp_t));
    check({tag, "_tick"}, 32'(frame_tick), 32'(exp_tick));
    check({tag, "_dir"}, 32'(dir), 32'(exp_dir));
  endtask

  initial begin
    reset     = 1'b1;
    y_px      = '0;
    cfg_valid = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    repeat (3) cyc();
    check("rst_t", 32'(t), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_running", 32'(running), 32'd1);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    reset = 1'b0;
    repeat (3) cyc();
    check("idle_y0_t", 32'(t), 32'd0);

    // Defaults: +1 per frame
    frame_expect("def1", 0, 2'd0, 20'h0, 20'd1, 1, 0);
    frame_expect("def2", 0, 2'd0, 20'h0, 20'd2, 1, 0);
    frame_expect("def3", 0, 2'd0, 20'h0, 20'd3, 1, 0);
    repeat (5) cyc();
    check("hold_y0_t", 32'(t), 32'd3);
    check("tick_count", 32'(ticks), 32'd3);

    // SPEED step=4 div=2: commit frame counts as first of three
    frame_expect("spd_a", 1, 2'd1, 20'h24, 20'd3, 0, 0);
    frame_expect("spd_b", 0, 2'd0, 20'h0, 20'd3, 0, 0);
    frame_expect("spd_c", 0, 2'd0, 20'h0, 20'd7, 1, 0);
    frame_expect("spd_d", 0, 2'd0, 20'h0, 20'd7, 0, 0);
    frame_expect("spd_e", 0, 2'd0, 20'h0, 20'd7, 0, 0);
    frame_expect("spd_f", 0, 2'd0, 20'h0, 20'd11, 1, 0);

    // Pause, then single step
    frame_expect("pause", 1, 2'd0, 20'h0, 20'd11, 0, 0);
    check("paused_running", 32'(running), 32'd0);
    frame_expect("paused2", 0, 2'd0, 20'h0, 20'd11, 0, 0);
    frame_expect("sstep", 1, 2'd0, 20'h4, 20'd15, 1, 0);
    check("sstep_running", 32'(running), 32'd0);
    frame_expect("after_step1", 0, 2'd0, 20'h0, 20'd15, 0, 0);
    frame_expect("after_step2", 0, 2'd0, 20'h0, 20'd15, 0, 0);

    // Load near the top, then wrap with step 3
    frame_expect("spd3", 1, 2'd1, 20'h03, 20'd15, 0, 0);
    frame_expect("load", 1, 2'd2, 20'hFFFFE, 20'hFFFFE, 1, 0);
    frame_expect("wrap", 1, 2'd0, 20'h1, 20'h00001, 1, 0);

    // Ping-pong between 0 and 10 with step 4
    frame_expect("pp_pause", 1, 2'd0, 20'h0, 20'h00001, 0, 0);
    frame_expect("pp_limit", 1, 2'd3, 20'd10, 20'h00001, 0, 0);
    frame_expect("pp_step4", 1, 2'd1, 20'h04, 20'h00001, 0, 0);
    frame_expect("pp_load0", 1, 2'd2, 20'h0, 20'd0, 1, 0);
    frame_expect("pp_s1", 1, 2'd0, 20'h3, 20'd4, 1, 0);
    frame_expect("pp_s2", 0, 2'd0, 20'h0, 20'd8, 1, 0);
    frame_expect("pp_s3", 0, 2'd0, 20'h0, 20'd10, 1, 1);
    frame_expect("pp_s4", 0, 2'd0, 20'h0, 20'd6, 1, 1);
    frame_expect("pp_s5", 0, 2'd0, 20'h0, 20'd2, 1, 1);
    frame_expect("pp_s6", 0, 2'd0, 20'h0, 20'd0, 1, 0);
    frame_expect("pp_s7", 0, 2'd0, 20'h0, 20'd4, 1, 0);

    // Reset with a T_LOAD pending mid-frame
    for (int y = 1; y < 525; y++) begin
      y_px = 10'(y);
      if (y == 100) begin
        cfg_valid = 1'b1;
        cfg_addr  = 2'd2;
        cfg_data  = 20'h12345;
      end
      if (y == 200) reset = 1'b1;
      if (y == 202) reset = 1'b0;
      cyc();
      if (y == 100) begin
        cfg_valid = 1'b0;
        check("pend_ready_low", 32'(cfg_ready), 32'd0);
      end
      if (y == 200) begin
        check("mid_rst_t", 32'(t), 32'd0);
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        check("mid_rst_running", 32'(running), 32'd1);
      end
    end
    y_px = '0;
    cyc();
    check("post_rst_t", 32'(t), 32'd1);
    check("post_rst_tick", 32'(frame_tick), 32'd1);
    frame_expect("post_rst2", 0, 2'd0, 20'h0, 20'd2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perlin_anim_ctrl.md
Name: perlin_anim_ctrl

Overview:
- Animation scheduler for the Perlin noise display; owns the time input `t` of the noise generator.
- Detects frame start from the VGA Y pixel position and advances `t` once per N frames by a programmable step.
- Supports run, pause, single-step, load and ping-pong (triangle) sweep.
- Configuration arrives through a valid/ready write port; every write is held in a one-entry pending slot and committed only at a frame boundary, so the image never changes mid-frame.

Parameters:
- TW, 20, width of `t` and of `cfg_data`.
- YW, 10, width of the Y pixel position.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- y_px  in  YW  current Y pixel position from the sync generator.
- cfg_valid  in  1  write request.
- cfg_ready  out  1  high when the pending slot is empty.
- cfg_addr  in  2  register select: 0 CTRL, 1 SPEED, 2 T_LOAD, 3 T_LIMIT.
- cfg_data  in  TW  write data.
- t  out  TW  animation time to the noise generator.
- frame_tick  out  1  one-cycle pulse on every cycle where `t` is advanced or loaded.
- dir  out  1  ping-pong direction, 0 = up.
- running  out  1  committed CTRL.run.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - t=0, dir=0, frame_tick=0, prev_y=0, div_cnt=0.
  - pending empty (cfg_ready=1), step_req=0.
  - Committed registers: run=1, pingpong=0, step=1, div=0, limit=all ones.
  - These defaults give plain +1 per frame.
- Frame start (fs): registered prev_y <= y_px every cycle. fs = (prev_y != y_px) && (y_px == 0). Only a transition into 0 counts; y_px held at 0 produces no further fs.
- Write handshake:
  - A write is accepted when cfg_valid && cfg_ready. Accepting it captures addr/data into the pending slot.
  - cfg_ready drops the next cycle and stays low until the fs cycle commits the slot; it is high again the cycle after the fs edge.
  - A write presented in the fs cycle itself, with the slot empty, is accepted and commits at the following fs.
- Register fields:
  - CTRL: [0] run, [1] pingpong, [2] step request. Writing bit 2 as 1 sets step_req at commit; bit 2 is not stored.
  - SPEED: [3:0] step, [7:4] div (advance every div+1 frames).
  - T_LOAD: value for `t`.
  - T_LIMIT: ping-pong upper bound.
- Per fs edge, in priority order:
  1. The pending write commits; register values take effect in the same edge.
  2. If the committed write was T_LOAD: t <= data, dir <= 0, div_cnt <= 0, frame_tick pulses, no advance this frame.
  3. Otherwise, if step_req (set by this commit or earlier): advance once, regardless of run and div; div_cnt <= 0; step_req <= 0.
  4. Otherwise, if run: if div_cnt == div, advance and div_cnt <= 0; else div_cnt <= div_cnt + 1.
  5. Otherwise (paused): t and div_cnt hold.
- Advance arithmetic:
  - pingpong=0: t <= t + step, modulo 2^TW (wrap from all ones to step-1).
  - pingpong=1, dir=0: if t + step >= limit (computed with TW+1 bits), t <= limit and dir <= 1; else t <= t + step.
  - pingpong=1, dir=1: if t <= step, t <= 0 and dir <= 0; else t <= t - step.
  - If t > limit when pingpong is enabled with dir=0, the first advance clamps t to limit.
  - step=0 leaves t unchanged, but frame_tick still pulses.
- frame_tick is registered: high exactly the cycle after the fs edge on which an advance or load occurred.
- No activity on non-fs cycles except handshake capture and prev_y update.
- Reset mid-frame or with a write pending discards the pending write and restores all reset values immediately.

Test Plan:
- Reset, then sweep y_px 0..524 repeatedly → t = 1, 2, 3 after 3 frames; frame_tick pulses 3 times; y_px held at 0 for 5 cycles gives no extra tick.
- Write SPEED step=4, div=2 mid-frame → cfg_ready low until next fs; afterwards t advances by 4 every 3rd frame (e.g. 5 → 9 → 13).
- Write CTRL run=0, then CTRL bits=0b100 → t frozen for frames; single step gives t+step exactly once, div_cnt reset, next frames frozen.
- Write T_LOAD 0xFFFFE, step=3, pingpong=0 → after load frame t=0xFFFFE, next frame t=0x00001 (wrap).
- Write T_LIMIT 10, CTRL run=1 pingpong=1, step=4 from t=0 → t sequence 4, 8, 10 (dir=1), 6, 2, 0 (dir=0), 4.
- Assert reset while a write is pending and mid-frame → t=0, cfg_ready=1, defaults restored; the discarded write never takes effect.
